// File: rtl/cpu16_ctrl_pkg.sv
// Shared encodings for the 16-bit CPU control unit: opcodes, functs,
// ALU slice select codes, ALU B-operand sources and FSM states.
package cpu16_ctrl_pkg;

    localparam int PC_STEP = 2;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b011;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_STEP = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_HALT
    } state_e;

endpackage

// File: rtl/cpu16_control_fsm_alu_op_decode.sv
// Combinational R-type funct decoder producing the ALU slice controls.
module alu_op_decode
    import cpu16_ctrl_pkg::*;
(
    input  logic [2:0] funct_i,
    output logic [2:0] aluSel_o,
    output logic       bInvert_o,
    output logic       carryIn_o,
    output logic       functIllegal_o
);

    // Subtract is ADD with B inverted and a carry in, giving A + ~B + 1.
    always_comb begin
        aluSel_o       = ALU_AND;
        bInvert_o      = 1'b0;
        carryIn_o      = 1'b0;
        functIllegal_o = 1'b0;
        case (funct_i)
            FN_AND: aluSel_o = ALU_AND;
            FN_OR:  aluSel_o = ALU_OR;
            FN_ADD: aluSel_o = ALU_ADD;
            FN_SUB: begin
                aluSel_o  = ALU_ADD;
                bInvert_o = 1'b1;
                carryIn_o = 1'b1;
            end
            FN_XOR: aluSel_o = ALU_XOR;
            default: functIllegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu16_control_fsm.sv
// Multi-cycle control FSM for the 16-bit CPU: fetch, decode, execute,
// memory and write-back sequencing with a memory ready handshake.
module cpu16_control_fsm
    import cpu16_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] instr_i,
    input  logic        zero_i,
    input  logic        memReady_i,
    output logic [2:0]  aluSel_o,
    output logic        bInvert_o,
    output logic        carryIn_o,
    output logic        aluSrcA_o,
    output logic [1:0]  aluSrcB_o,
    output logic        memRead_o,
    output logic        memWrite_o,
    output logic        iorD_o,
    output logic        irWrite_o,
    output logic        pcWrite_o,
    output logic        pcSource_o,
    output logic        regWrite_o,
    output logic        regDst_o,
    output logic        memToReg_o,
    output logic        illegal_o,
    output logic        halted_o
);

    state_e     state_q, state_d;
    logic [3:0] opcode;
    logic [2:0] fnAluSel;
    logic       fnBInvert, fnCarryIn, fnIllegal;
    state_e     trapState;

    assign opcode    = instr_i[15:12];
    assign trapState = ILLEGAL_TRAP ? S_FETCH : S_HALT;

    alu_op_decode uAluOpDecode (
        .funct_i        (instr_i[2:0]),
        .aluSel_o       (fnAluSel),
        .bInvert_o      (fnBInvert),
        .carryIn_o      (fnCarryIn),
        .functIllegal_o (fnIllegal)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Every output defaults to 0 and stays 0 while reset is held.
    always_comb begin
        state_d    = state_q;
        aluSel_o   = ALU_AND;
        bInvert_o  = 1'b0;
        carryIn_o  = 1'b0;
        aluSrcA_o  = 1'b0;
        aluSrcB_o  = SRCB_REG;
        memRead_o  = 1'b0;
        memWrite_o = 1'b0;
        iorD_o     = 1'b0;
        irWrite_o  = 1'b0;
        pcWrite_o  = 1'b0;
        pcSource_o = 1'b0;
        regWrite_o = 1'b0;
        regDst_o   = 1'b0;
        memToReg_o = 1'b0;
        illegal_o  = 1'b0;
        halted_o   = 1'b0;
        if (!reset_i) begin
            case (state_q)
                S_FETCH: begin
                    memRead_o = 1'b1;
                    aluSrcB_o = SRCB_STEP;
                    aluSel_o  = ALU_ADD;
                    if (memReady_i) begin
                        irWrite_o = 1'b1;
                        pcWrite_o = 1'b1;
                        state_d   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    aluSrcB_o = SRCB_IMM;
                    aluSel_o  = ALU_ADD;
                    case (opcode)
                        OP_RTYPE:      state_d = S_EXEC_R;
                        OP_ADDI:       state_d = S_EXEC_I;
                        OP_LW, OP_SW:  state_d = S_ADDR;
                        OP_BEQ:        state_d = S_BRANCH;
                        OP_HALT:       state_d = S_HALT;
                        default: begin
                            illegal_o = 1'b1;
                            state_d   = trapState;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    aluSrcA_o = 1'b1;
                    aluSrcB_o = SRCB_REG;
                    aluSel_o  = fnAluSel;
                    bInvert_o = fnBInvert;
                    carryIn_o = fnCarryIn;
                    if (fnIllegal) begin
                        illegal_o = 1'b1;
                        state_d   = trapState;
                    end else begin
                        state_d = S_WB_ALU;
                    end
                end
                S_EXEC_I, S_ADDR: begin
                    aluSrcA_o = 1'b1;
                    aluSrcB_o = SRCB_IMM;
                    aluSel_o  = ALU_ADD;
                    if (state_q == S_EXEC_I) state_d = S_WB_ALU;
                    else state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    memRead_o = 1'b1;
                    iorD_o    = 1'b1;
                    if (memReady_i) state_d = S_WB_MEM;
                end
                S_MEM_WR: begin
                    memWrite_o = 1'b1;
                    iorD_o     = 1'b1;
                    if (memReady_i) state_d = S_FETCH;
                end
                S_WB_ALU: begin
                    regWrite_o = 1'b1;
                    regDst_o   = (opcode == OP_RTYPE);
                    state_d    = S_FETCH;
                end
                S_WB_MEM: begin
                    regWrite_o = 1'b1;
                    memToReg_o = 1'b1;
                    state_d    = S_FETCH;
                end
                // Branch compares A-B; the PC loads ALUOut only when the result is zero.
                S_BRANCH: begin
                    aluSrcA_o  = 1'b1;
                    aluSrcB_o  = SRCB_REG;
                    aluSel_o   = ALU_ADD;
                    bInvert_o  = 1'b1;
                    carryIn_o  = 1'b1;
                    pcSource_o = 1'b1;
                    pcWrite_o  = zero_i;
                    state_d    = S_FETCH;
                end
                S_HALT: halted_o = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu16_control_fsm.sv
// Directed self-checking bench for cpu16_control_fsm; every control output
// is compared as one packed vector against hand-written per-state values.
module tb_cpu16_control_fsm;

    typedef struct packed {
        logic [2:0] sel;
        logic       binv;
        logic       cin;
        logic       srcA;
        logic [1:0] srcB;
        logic       mr;
        logic       mw;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
        logic       halt;
    } ctrl_t;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        zero;
    logic        memReady;
    logic [2:0]  aluSel;
    logic        bInvert, carryIn, aluSrcA;
    logic [1:0]  aluSrcB;
    logic        memRead, memWrite, iorD, irWrite, pcWrite, pcSource;
    logic        regWrite, regDst, memToReg, illegal, halted;
    ctrl_t       obs;
    int          testsRun = 0;
    int          testsFailed = 0;

    cpu16_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .instr_i    (instr),
        .zero_i     (zero),
        .memReady_i (memReady),
        .aluSel_o   (aluSel),
        .bInvert_o  (bInvert),
        .carryIn_o  (carryIn),
        .aluSrcA_o  (aluSrcA),
        .aluSrcB_o  (aluSrcB),
        .memRead_o  (memRead),
        .memWrite_o (memWrite),
        .iorD_o     (iorD),
        .irWrite_o  (irWrite),
        .pcWrite_o  (pcWrite),
        .pcSource_o (pcSource),
        .regWrite_o (regWrite),
        .regDst_o   (regDst),
        .memToReg_o (memToReg),
        .illegal_o  (illegal),
        .halted_o   (halted)
    );

    assign obs = {aluSel, bInvert, carryIn, aluSrcA, aluSrcB, memRead, memWrite, iorD,
                  irWrite, pcWrite, pcSource, regWrite, regDst, memToReg, illegal, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t expFetch(input logic ready);
        ctrl_t e = '0;
        e.mr = 1'b1; e.srcB = 2'b01; e.sel = 3'b100; e.irw = ready; e.pcw = ready;
        return e;
    endfunction

    function automatic ctrl_t expDecode(input logic ill);
        ctrl_t e = '0;
        e.srcB = 2'b10; e.sel = 3'b100; e.ill = ill;
        return e;
    endfunction

    function automatic ctrl_t expExecR(input logic [2:0] sel, input logic sub, input logic ill);
        ctrl_t e = '0;
        e.srcA = 1'b1; e.sel = sel; e.binv = sub; e.cin = sub; e.ill = ill;
        return e;
    endfunction

    function automatic ctrl_t expImm();
        ctrl_t e = '0;
        e.srcA = 1'b1; e.srcB = 2'b10; e.sel = 3'b100;
        return e;
    endfunction

    function automatic ctrl_t expWb(input logic rd, input logic m2r);
        ctrl_t e = '0;
        e.rw = 1'b1; e.rd = rd; e.m2r = m2r;
        return e;
    endfunction

    function automatic ctrl_t expMem(input logic wr);
        ctrl_t e = '0;
        e.iord = 1'b1; e.mr = ~wr; e.mw = wr;
        return e;
    endfunction

    function automatic ctrl_t expBranch(input logic z);
        ctrl_t e = '0;
        e.srcA = 1'b1; e.sel = 3'b100; e.binv = 1'b1; e.cin = 1'b1; e.pcs = 1'b1; e.pcw = z;
        return e;
    endfunction

    function automatic ctrl_t expHalt();
        ctrl_t e = '0;
        e.halt = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input logic [15:0] instrV, input logic zeroV, input logic readyV);
        instr    = instrV;
        zero     = zeroV;
        memReady = readyV;
        #1;
    endtask

    task automatic checkOutput(input string tag, input ctrl_t observed, input ctrl_t expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, compare the outputs of the current state, then clock once.
    task automatic step(input string tag, input logic [15:0] instrV, input logic zeroV,
                        input logic readyV, input ctrl_t expected);
        applyStimulus(instrV, zeroV, readyV);
        checkOutput(tag, obs, expected);
        tick();
    endtask

    logic [2:0] fnCode [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [2:0] fnSel  [4] = '{3'b000, 3'b010, 3'b100, 3'b011};

    initial begin
        reset = 1'b1;
        applyStimulus(16'h0000, 1'b0, 1'b1);
        tick();
        checkOutput("reset_gated", obs, '0);
        tick();
        reset = 1'b0;

        step("sub_fetch",  16'h0043, 1'b0, 1'b1, expFetch(1'b1));
        step("sub_decode", 16'h0043, 1'b0, 1'b1, expDecode(1'b0));
        step("sub_exec",   16'h0043, 1'b0, 1'b1, expExecR(3'b100, 1'b1, 1'b0));
        step("sub_wb",     16'h0043, 1'b0, 1'b1, expWb(1'b1, 1'b0));

        step("fetch_wait0", 16'h1005, 1'b0, 1'b0, expFetch(1'b0));
        step("fetch_wait1", 16'h1005, 1'b0, 1'b0, expFetch(1'b0));
        step("addi_fetch",  16'h1005, 1'b0, 1'b1, expFetch(1'b1));
        step("addi_decode", 16'h1005, 1'b1, 1'b1, expDecode(1'b0));
        step("addi_exec",   16'h1005, 1'b0, 1'b1, expImm());
        step("addi_wb",     16'h1005, 1'b0, 1'b1, expWb(1'b0, 1'b0));

        for (int i = 0; i < 4; i++) begin
            step("rfn_fetch",  {13'h0000, fnCode[i]}, 1'b0, 1'b1, expFetch(1'b1));
            step("rfn_decode", {13'h0000, fnCode[i]}, 1'b0, 1'b1, expDecode(1'b0));
            step("rfn_exec",   {13'h0000, fnCode[i]}, 1'b0, 1'b1, expExecR(fnSel[i], 1'b0, 1'b0));
            step("rfn_wb",     {13'h0000, fnCode[i]}, 1'b0, 1'b1, expWb(1'b1, 1'b0));
        end

        step("lw_fetch",  16'h2010, 1'b0, 1'b1, expFetch(1'b1));
        step("lw_decode", 16'h2010, 1'b0, 1'b1, expDecode(1'b0));
        step("lw_addr",   16'h2010, 1'b0, 1'b1, expImm());
        for (int i = 0; i < 3; i++) step("lw_memwait", 16'h2010, 1'b0, 1'b0, expMem(1'b0));
        step("lw_memrd",  16'h2010, 1'b0, 1'b1, expMem(1'b0));
        step("lw_wb",     16'h2010, 1'b0, 1'b0, expWb(1'b0, 1'b1));

        step("sw_fetch",  16'h3010, 1'b0, 1'b1, expFetch(1'b1));
        step("sw_decode", 16'h3010, 1'b0, 1'b1, expDecode(1'b0));
        step("sw_addr",   16'h3010, 1'b0, 1'b1, expImm());
        step("sw_memwr",  16'h3010, 1'b0, 1'b1, expMem(1'b1));

        step("beq1_fetch",  16'h4003, 1'b1, 1'b1, expFetch(1'b1));
        step("beq1_decode", 16'h4003, 1'b1, 1'b1, expDecode(1'b0));
        step("beq1_branch", 16'h4003, 1'b1, 1'b1, expBranch(1'b1));
        step("beq0_fetch",  16'h4003, 1'b0, 1'b1, expFetch(1'b1));
        step("beq0_decode", 16'h4003, 1'b0, 1'b1, expDecode(1'b0));
        step("beq0_branch", 16'h4003, 1'b0, 1'b1, expBranch(1'b0));

        step("badop_fetch",  16'h7000, 1'b0, 1'b1, expFetch(1'b1));
        step("badop_decode", 16'h7000, 1'b0, 1'b1, expDecode(1'b1));
        step("badfn_fetch",  16'h0006, 1'b0, 1'b1, expFetch(1'b1));
        step("badfn_decode", 16'h0006, 1'b0, 1'b1, expDecode(1'b0));
        step("badfn_exec",   16'h0006, 1'b0, 1'b1, expExecR(3'b000, 1'b0, 1'b1));
        step("badfn_trap",   16'h0006, 1'b0, 1'b1, expFetch(1'b1));

        step("rst_decode", 16'h3020, 1'b0, 1'b1, expDecode(1'b0));
        step("rst_addr",   16'h3020, 1'b0, 1'b1, expImm());
        applyStimulus(16'h3020, 1'b0, 1'b0);
        checkOutput("rst_memwr", obs, expMem(1'b1));
        reset = 1'b1;
        #1;
        checkOutput("rst_in_memwr", obs, '0);
        tick();
        reset = 1'b0;
        step("rst_fetch", 16'h3020, 1'b0, 1'b0, expFetch(1'b0));

        step("halt_fetch",  16'hF000, 1'b0, 1'b1, expFetch(1'b1));
        step("halt_decode", 16'hF000, 1'b0, 1'b1, expDecode(1'b0));
        for (int i = 0; i < 4; i++) step("halt_sticky", 16'hF000, 1'b0, logic'(i[0]), expHalt());
        reset = 1'b1;
        applyStimulus(16'hF000, 1'b0, 1'b1);
        checkOutput("halt_reset", obs, '0);
        tick();
        reset = 1'b0;
        step("halt_exit", 16'hF000, 1'b0, 1'b1, expFetch(1'b1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cpu16_control_fsm.md
Name: cpu16_control_fsm

Overview:
Multi-cycle control unit for the 16-bit CPU, directly upstream of the per-bit ALU result multiplexers. It sequences fetch, decode, execute, memory and write-back. It drives the 3-bit ALU select code consumed by every 1-bit ALU slice, plus the B-invert and carry-in controls. It also handles the memory ready handshake and the datapath write enables.

Parameters:
- PC_STEP, 2, constant selected on ALUSrcB=01 for PC increment (byte-addressed 16-bit words).
- ILLEGAL_TRAP, 1, 1: an illegal opcode/funct pulses Illegal and returns to FETCH. 0: the FSM enters HALT.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Instr  in  16  instruction register contents. Opcode=[15:12], funct=[2:0].
- Zero  in  1  ALU zero flag (16-bit result == 0).
- MemReady  in  1  memory completes the current read/write this cycle.
- ALUSel  out  3  to ALU slices: AND=000, OR=010, ADD=100, XOR=011.
- BInvert  out  1  invert B operand (subtract).
- CarryIn  out  1  carry into bit 0.
- ALUSrcA  out  1  0=PC, 1=register A.
- ALUSrcB  out  2  00=reg B, 01=PC_STEP, 10=sign-extended Instr[7:0].
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IorD  out  1  0=PC address, 1=ALUOut address.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC.
- PCSource  out  1  0=ALU result, 1=ALUOut (branch target).
- RegWrite  out  1  register-file write.
- RegDst  out  1  0=rt, 1=rd.
- MemToReg  out  1  0=ALUOut, 1=memory data register.
- Illegal  out  1  one-cycle pulse on an undefined opcode/funct.
- Halted  out  1  sticky once HALT is reached.

Behaviour:
- Opcodes: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 1111 HALT. All others are illegal.
- R-type funct: 000 AND, 001 OR, 010 ADD, 011 SUB (ADD+BInvert+CarryIn), 100 XOR. Funct 101-111 is illegal.
- States (4-bit): FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUSel=ADD.
  - Stays in FETCH while MemReady=0.
  - On MemReady=1, IRWrite=1 and PCWrite=1 in that same cycle (Mealy), then go to DECODE.
- DECODE:
  - ALU computes the branch target: ALUSrcA=0, ALUSrcB=10, ADD.
  - Next state by opcode: R->EXEC_R, ADDI->EXEC_I, LW/SW->ADDR, BEQ->BRANCH, HALT->HALT.
  - Illegal: Illegal=1 for one cycle, then FETCH (ILLEGAL_TRAP=1) or HALT (ILLEGAL_TRAP=0).
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUSel/BInvert/CarryIn from funct. An illegal funct is handled as in DECODE with no register write. Otherwise go to WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ADD. Next state WB_ALU.
- WB_ALU: RegWrite=1, MemToReg=0, RegDst=1 for R-type and 0 for ADDI. Next state FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ADD. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Holds until MemReady=1, then WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Holds until MemReady=1, then FETCH.
- WB_MEM: RegWrite=1, MemToReg=1, RegDst=0. Next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUSel=ADD, BInvert=1, CarryIn=1 (A-B).
  - PCSource=1, PCWrite=Zero (combinational). Next state FETCH.
- HALT: all strobes 0, Halted=1. Only Reset leaves HALT.
- Minimum latencies with MemReady tied to 1: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3.
- Any output not listed for a state is 0. MemRead and MemWrite are never both 1.
- Reset:
  - While Reset=1, every output is 0 (gated), including Halted.
  - The next state is FETCH. Mid-operation reset abandons the instruction with no RegWrite, PCWrite or MemWrite.
  - First cycle after release: FETCH with MemRead=1.
- MemReady outside FETCH, MEM_RD and MEM_WR is ignored.

Decomposition:
- Package cpu16_ctrl_pkg holds opcode constants, funct constants, ALUSel codes (AND/OR/ADD/XOR), the ALUSrcB encodings and the state encoding.
- Sub-module alu_op_decode: combinational funct -> {ALUSel, BInvert, CarryIn, funct_illegal}. It is shared by EXEC_R and reusable by the ALU testbench.

Test Plan:
- R-type SUB (Instr=0x0043, funct 011), MemReady=1 -> FETCH, DECODE, EXEC_R (ALUSel=100, BInvert=1, CarryIn=1), WB_ALU (RegWrite=1, RegDst=1). 4 cycles.
- LW (0x2xxx) with MemReady low 3 cycles in MEM_RD -> MemRead held, IorD=1, no state advance. WB_MEM follows in the cycle after MemReady=1. RegWrite=1, MemToReg=1.
- BEQ (0x4xxx), Zero=1, then a repeat with Zero=0 -> PCWrite=1 and PCSource=1 in BRANCH only when Zero=1. Back to FETCH in both cases.
- Opcode 0x7 and R-type funct 110 -> Illegal pulses exactly 1 cycle. No RegWrite or MemWrite. Next FETCH (ILLEGAL_TRAP=1).
- HALT (0xF000) -> Halted=1 persists with MemReady toggling. Reset=1 for one cycle returns to FETCH with Halted=0.
- Reset asserted in MEM_WR with MemReady=0 -> MemWrite drops that cycle, all outputs 0. After release, FETCH with MemRead=1.
